// File: rtl/gf2_pkg.sv
// Shared types and width helpers for the GF(2)[x] long divider.
package gf2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int N_DEFAULT = 256;
   // Degree index width for the default operand width.
   localparam int DEG_W = $clog2(N_DEFAULT);
   // Step-counter width: walks every dividend coefficient 2N-1 .. 0.
   localparam int CNT_W = $clog2(2 * N_DEFAULT);

   // Degree index width for an arbitrary operand width (at least one bit).
   function automatic int deg_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Step-counter width for an arbitrary operand width.
   function automatic int cnt_width(input int n);
      return $clog2(2 * n);
   endfunction

endpackage

// File: rtl/gf2_poly_divider_degree_enc.sv
// gf2_degree_enc: priority encoder returning the index of the highest set
// coefficient of an N-bit polynomial (bit i = x^i) plus an all-zero flag.
module gf2_degree_enc
   import gf2_pkg::*;
#(
   parameter int N  = 256,
   parameter int DW = deg_width(N)
) (
   input  logic [N-1:0]  poly,
   output logic [DW-1:0] degree,
   output logic          zero
);

   // Scan upward so the highest set coefficient wins.
   always_comb begin
      degree = '0;
      zero   = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (poly[i]) begin
            degree = DW'(i);
            zero   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider: sequential GF(2)[x] long division, one dividend
// coefficient per cycle, valid/ready on both sides.
// Optional macro GF2DIV_ERR_FLAG_EN adds the div_by_zero output.
module gf2_poly_divider
   import gf2_pkg::*;
#(
   parameter int N = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:2*N-1] dividend,
   input  logic [0:N-1] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:2*N-1] quotient,
`ifdef GF2DIV_ERR_FLAG_EN
   output logic [0:N-1] remainder,
   output logic         div_by_zero
`else
   output logic [0:N-1] remainder
`endif
);

   localparam int DW = deg_width(N);
   localparam int KW = cnt_width(N);
   localparam int W2 = 2 * N;

   state_t          state_reg, state_next;
   logic [W2-1:0]   rem_reg;     // running remainder, bit i = x^i
   logic [W2-1:0]   dal_reg;     // divisor, aligned so its lead term sits at k
   logic [W2-1:0]   q_reg;       // quotient, filled by shifting in from bit 0
   logic [KW-1:0]   k_reg;       // coefficient currently being eliminated
   logic [DW-1:0]   d_reg;       // divisor degree
   logic [W2-1:0]   dvd_le;
   logic [N-1:0]    dvs_le;
   logic [DW-1:0]   enc_degree;
   logic            enc_zero;
   logic [KW-1:0]   align_shift;
   logic            lead_bit;

   genvar gi;

   // Port vectors are indexed by coefficient; map them onto internal vectors.
   generate
      for (gi = 0; gi < W2; gi++) begin : g_wide
         assign dvd_le[gi]   = dividend[gi];
         assign quotient[gi] = q_reg[gi];
      end
      for (gi = 0; gi < N; gi++) begin : g_narrow
         assign dvs_le[gi]    = divisor[gi];
         assign remainder[gi] = rem_reg[gi];
      end
   endgenerate

   // During LOAD the low half of dal_reg still holds the raw divisor.
   gf2_degree_enc #(.N(N), .DW(DW)) u_degree_enc (
      .poly   (dal_reg[N-1:0]),
      .degree (enc_degree),
      .zero   (enc_zero)
   );

   assign align_shift = KW'(W2 - 1) - KW'(enc_degree);
   assign lead_bit    = rem_reg[k_reg];

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = LOAD;
         end
         LOAD: state_next = enc_zero ? DONE : DIV;
         DIV:  if (k_reg == KW'(d_reg)) state_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef GF2DIV_ERR_FLAG_EN
   logic err_reg;
   assign div_by_zero = err_reg;
`endif

   // Datapath: latch operands, align divisor once, then one elimination step per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_reg <= '0;
         dal_reg <= '0;
         q_reg   <= '0;
         k_reg   <= '0;
         d_reg   <= '0;
`ifdef GF2DIV_ERR_FLAG_EN
         err_reg <= 1'b0;
`endif
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  rem_reg <= dvd_le;
                  dal_reg <= {{N{1'b0}}, dvs_le};
                  q_reg   <= '0;
`ifdef GF2DIV_ERR_FLAG_EN
                  err_reg <= 1'b0;
`endif
               end
            end
            LOAD: begin
               d_reg   <= enc_degree;
               k_reg   <= KW'(W2 - 1);
               dal_reg <= dal_reg << align_shift;
`ifdef GF2DIV_ERR_FLAG_EN
               err_reg <= enc_zero;
`endif
            end
            DIV: begin
               if (lead_bit) rem_reg <= rem_reg ^ dal_reg;
               q_reg   <= {q_reg[W2-2:0], lead_bit};
               dal_reg <= dal_reg >> 1;
               k_reg   <= k_reg - KW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and product-reduction checks for gf2_poly_divider (N=4 and N=8).
module tb_gf2_poly_divider;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // N=4 instance
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid;
   logic [0:7] dividend = '0;
   logic [0:3] divisor = '0;
   logic [0:7] quotient;
   logic [0:3] remainder;
`ifdef GF2DIV_ERR_FLAG_EN
   logic       div_by_zero;
`endif

   gf2_poly_divider #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .out_ready(out_ready), .quotient(quotient),
`ifdef GF2DIV_ERR_FLAG_EN
      .remainder(remainder), .div_by_zero(div_by_zero)
`else
      .remainder(remainder)
`endif
   );

   // N=8 instance
   logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
   logic        in_ready8, out_valid8;
   logic [0:15] dividend8 = '0;
   logic [0:7]  divisor8 = '0;
   logic [0:15] quotient8;
   logic [0:7]  remainder8;
`ifdef GF2DIV_ERR_FLAG_EN
   logic        div_by_zero8;
`endif

   gf2_poly_divider #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .dividend(dividend8), .divisor(divisor8), .out_valid(out_valid8),
      .out_ready(out_ready8), .quotient(quotient8),
`ifdef GF2DIV_ERR_FLAG_EN
      .remainder(remainder8), .div_by_zero(div_by_zero8)
`else
      .remainder(remainder8)
`endif
   );

   // Present one operand pair for exactly the accept edge.
   task automatic send4(input logic [0:7] a, input logic [0:3] b);
      @(negedge clk);
      dividend = a; divisor = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Count posedges after the accept edge until out_valid; -1 on timeout.
   task automatic wait4(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic pop4();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (quotient !== 8'b0) begin bad++; $display("FAIL reset_quotient got=%b want=0", quotient); end
      total++; if (remainder !== 4'b0) begin bad++; $display("FAIL reset_remainder got=%b want=0", remainder); end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   // (x^4+x^3+x^2+1)/(x+1) and (x^5+1)/(x^2+x+1)
   task automatic test_divide();
      int lat;
      send4(8'b10111000, 4'b1100);
      wait4(lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL div1_latency got=%0d want=8", lat); end
      total++; if (quotient !== 8'b11010000) begin bad++; $display("FAIL div1_quotient got=%b want=11010000", quotient); end
      total++; if (remainder !== 4'b0000) begin bad++; $display("FAIL div1_remainder got=%b want=0000", remainder); end
      $display("div1: q=%b r=%b lat=%0d", quotient, remainder, lat);
      pop4();
      send4(8'b10000100, 4'b1110);
      wait4(lat);
      total++; if (lat !== 7) begin bad++; $display("FAIL div2_latency got=%0d want=7", lat); end
      total++; if (quotient !== 8'b10110000) begin bad++; $display("FAIL div2_quotient got=%b want=10110000", quotient); end
      total++; if (remainder !== 4'b0100) begin bad++; $display("FAIL div2_remainder got=%b want=0100", remainder); end
      $display("div2: q=%b r=%b lat=%0d", quotient, remainder, lat);
      pop4();
   endtask

   task automatic test_zero_divisor();
      int lat;
      send4(8'b11110101, 4'b0000);
      wait4(lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
      total++; if (quotient !== 8'b0) begin bad++; $display("FAIL zero_quotient got=%b want=0", quotient); end
      total++; if (remainder !== 4'b1111) begin bad++; $display("FAIL zero_remainder got=%b want=1111", remainder); end
`ifdef GF2DIV_ERR_FLAG_EN
      total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL zero_flag got=%b want=1", div_by_zero); end
`endif
      $display("zero: q=%b r=%b lat=%0d", quotient, remainder, lat);
      pop4();
   endtask

   // Divisor 1 (degree 0): quotient equals dividend, longest latency.
   task automatic test_unit_divisor();
      int lat;
      send4(8'b01101001, 4'b1000);
      wait4(lat);
      total++; if (lat !== 9) begin bad++; $display("FAIL unit_latency got=%0d want=9", lat); end
      total++; if (quotient !== 8'b01101001) begin bad++; $display("FAIL unit_quotient got=%b want=01101001", quotient); end
      total++; if (remainder !== 4'b0000) begin bad++; $display("FAIL unit_remainder got=%b want=0000", remainder); end
`ifdef GF2DIV_ERR_FLAG_EN
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL unit_flag got=%b want=0", div_by_zero); end
`endif
      $display("unit: q=%b r=%b lat=%0d", quotient, remainder, lat);
      pop4();
   endtask

   task automatic test_backpressure();
      int lat;
      send4(8'b10111000, 4'b1100);
      wait4(lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         dividend = 8'b11111111; divisor = 4'b1010; in_valid = 1'b1;
         total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL hold_handshake got=%b%b want=10", out_valid, in_ready); end
         total++; if (quotient !== 8'b11010000 || remainder !== 4'b0000) begin bad++; $display("FAIL hold_data got=%b/%b want=11010000/0000", quotient, remainder); end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL handshake_cycle_ready got=%b want=0", in_ready); end
      @(posedge clk);
      #1 out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL after_pop got=%b%b want=10", in_ready, out_valid); end
      $display("backpressure: released, in_ready=%b", in_ready);
      send4(8'b10000100, 4'b1110);
      wait4(lat);
      total++; if (lat !== 7 || quotient !== 8'b10110000 || remainder !== 4'b0100) begin bad++; $display("FAIL post_bp got=%0d/%b/%b want=7/10110000/0100", lat, quotient, remainder); end
      pop4();
   endtask

   task automatic test_reset_mid();
      int lat;
      send4(8'b10111000, 4'b1100);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_handshake got=%b%b want=10", in_ready, out_valid); end
      total++; if (quotient !== 8'b0 || remainder !== 4'b0) begin bad++; $display("FAIL midrst_data got=%b/%b want=0/0", quotient, remainder); end
      @(negedge clk);
      rst_n = 1'b1;
      send4(8'b10000100, 4'b1110);
      wait4(lat);
      total++; if (lat !== 7 || quotient !== 8'b10110000 || remainder !== 4'b0100) begin bad++; $display("FAIL midrst_next got=%0d/%b/%b want=7/10110000/0100", lat, quotient, remainder); end
      $display("reset_mid: next q=%b r=%b", quotient, remainder);
      pop4();
   endtask

   // Carry-less product, bit i = x^i.
   function automatic logic [0:15] clmul8(input logic [0:7] a, input logic [0:7] b);
      logic [0:15] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            p[i+j] = p[i+j] ^ (a[i] & b[j]);
      return p;
   endfunction

   task automatic test_random8();
      logic [0:7]  a, b;
      logic [0:15] expq;
      int deg, lat;
      for (int v = 0; v < 1000; v++) begin
         a = 8'($urandom);
         b = 8'($urandom_range(1, 255));
         deg = 0;
         for (int i = 0; i < 8; i++) if (b[i]) deg = i;
         expq = '0;
         for (int i = 0; i < 8; i++) expq[i] = a[i];
         @(negedge clk);
         dividend8 = clmul8(a, b); divisor8 = b; in_valid8 = 1'b1;
         @(posedge clk);
         #1 in_valid8 = 1'b0;
         lat = -1;
         for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid8) begin lat = i; break; end
         end
         total++; if (lat !== 17 - deg) begin bad++; $display("FAIL rand_latency v=%0d got=%0d want=%0d", v, lat, 17 - deg); end
         total++; if (quotient8 !== expq) begin bad++; $display("FAIL rand_quotient v=%0d got=%b want=%b", v, quotient8, expq); end
         total++; if (remainder8 !== 8'b0) begin bad++; $display("FAIL rand_remainder v=%0d got=%b want=0", v, remainder8); end
         $display("rand %0d: a=%b b=%b q=%b r=%b lat=%0d", v, a, b, quotient8, remainder8, lat);
         @(negedge clk);
         out_ready8 = 1'b1;
         @(posedge clk);
         #1 out_ready8 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_zero_divisor();
      test_unit_divisor();
      test_backpressure();
      test_reset_mid();
      test_random8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
